mem_access_arbiter: RTL
=======================

Name: mem_access_arbiter

Overview:
- Parametrised, multi-port successor to the single-client memory access block for the CHIP-8 core.
- Arbitrates N client ports onto one single-port synchronous RAM (4 KB CHIP-8 space).
- Client ports are opcode fetch, execute (FX55/FX65/FX33, I-relative loads) and sprite/display reads.
- Supports 1..MAX_BURST byte bursts with 12-bit address wrap, round-robin fairness and write protection of the interpreter/font region.

Parameters:
- NUM_PORTS, 3, number of client ports.
- ADDR_W, 12, byte address width.
- DATA_W, 8, data width.
- MAX_BURST, 16, maximum beats per request.
- LEN_W, $clog2(MAX_BURST), burst length field width; encoding is beats-1.
- PROT_EN, 1, enable write protection.
- PROT_END, 12'h200, writes to addresses below this value are blocked.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_ready  out  NUM_PORTS  one-hot acceptance pulse.
- req_write  in  NUM_PORTS  1=write burst, 0=read burst.
- req_addr  in  NUM_PORTS*ADDR_W  start address, packed by port.
- req_len  in  NUM_PORTS*LEN_W  beats-1, packed.
- wr_ready  out  NUM_PORTS  write beat strobe to owner.
- wr_beat  out  LEN_W  current beat index.
- wr_data  in  NUM_PORTS*DATA_W  write data; must be valid combinationally for wr_beat.
- rd_valid  out  NUM_PORTS  read data strobe.
- rd_last  out  1  final read beat.
- rd_data  out  DATA_W  read data, shared by all ports.
- prot_err  out  NUM_PORTS  one-cycle pulse per blocked write beat.
- busy  out  1  burst in progress.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Interface decisions: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0. All strobes (req_ready, wr_ready, rd_valid, rd_last, prot_err, mem_en, mem_we) are 0. busy=0. mem_addr=0, wr_beat=0.
- States:
  - IDLE: if any req_valid, grant the first requester at or after rr_ptr in ascending order with wrap. Pulse req_ready[g] that cycle. Latch write, addr, len and owner g. Set rr_ptr=(g+1) mod NUM_PORTS. Go to BURST.
  - BURST: one RAM beat per cycle, beat k at address (addr+k) mod 2^ADDR_W. On k==len go to IDLE. busy=1 throughout BURST.
- Latency: request accepted at cycle 0; beat 0 reaches RAM at cycle 1; read data returns at cycle 2. Back-to-back grants are allowed: the next acceptance can occur in the IDLE cycle after the last beat.
- Read beat: mem_en=1, mem_we=0. A one-stage registered owner/last tag travels with the beat. Next cycle: rd_valid[owner]=1, rd_data=mem_rdata (passed through), rd_last=tag.last. A pending read return completes even if IDLE grants a new owner in that same cycle.
- Write beat: wr_ready[owner]=1, wr_beat=k, mem_wdata=wr_data[owner], mem_en=1.
  - mem_we=1 unless PROT_EN and (addr+k) mod 2^ADDR_W < PROT_END.
  - For a blocked beat: mem_we=0 and prot_err[owner]=1. The burst still advances.
- A deasserted req_valid during BURST is ignored; clients must not withdraw a request before req_ready.
- Wrap: address 0xFFF+1 becomes 0x000. After a wrap, a write burst may enter the protected region and gets blocked beats.
- Reset mid-burst: the burst is aborted. The pending rd_valid is suppressed the next cycle. There is no partial completion.
- rd_valid and wr_ready are never asserted for a port other than the latched owner.

Decomposition:
- Package chip8_mem_pkg holds: ADDR_W/DATA_W defaults, PROT_END, the port index constants (PORT_FETCH=0, PORT_EXEC=1, PORT_DISP=2), and the state enum (IDLE, BURST).
- One sub-module, rr_arbiter: combinational grant from req_valid and rr_ptr, producing a one-hot grant and its index.

Test Plan:
- Single read: port 0 reads addr 0x200, len=1 (2 beats), RAM holds 0xA2,0xF0 → rd_valid[0] at cycles 2 and 3 with data 0xA2 then 0xF0; rd_last on 0xF0.
- Round robin: all three ports request 1-beat reads simultaneously and hold → grant order 0,1,2,0; each req_ready exactly one cycle.
- FX55 store: port 1 writes addr 0x300, len=15, wr_data=16*beat → 16 mem_we beats at 0x300..0x30F with data 0x00..0xF0; no prot_err.
- Protection: port 1 writes addr 0x1FE, len=3 → beats at 0x1FE/0x1FF blocked (mem_we=0, prot_err[1] two pulses); 0x200/0x201 written.
- Wrap: port 2 reads addr 0xFFE, len=3 → mem_addr sequence 0xFFE, 0xFFF, 0x000, 0x001.
- Reset mid-burst: assert rst at beat 2 of an 8-beat read → next cycle all outputs at reset values, no rd_valid; a new request after release is served normally.

Source files
------------

// File: rtl/mem_access_arbiter_pkg.sv
// Shared constants and types for the CHIP-8 multi-port memory arbiter.
// Port indices name the three clients: opcode fetch, execute unit and display.
package chip8_mem_pkg;

    localparam int          ADDR_W_DEF   = 12;
    localparam int          DATA_W_DEF   = 8;
    localparam logic [11:0] PROT_END_DEF = 12'h200;

    localparam int PORT_FETCH = 0;
    localparam int PORT_EXEC  = 1;
    localparam int PORT_DISP  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Index width that stays legal when only one port exists.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Client request/beat bus plus RAM-side signals of the memory arbiter.
// The arbiter uses the slave view; clients and the RAM model use the master view.
interface mem_access_arbiter_if
    import chip8_mem_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int LEN_W     = 4
);
    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [NUM_PORTS-1:0]        req_write;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*LEN_W-1:0]  req_len;
    logic [NUM_PORTS-1:0]        wr_ready;
    logic [LEN_W-1:0]            wr_beat;
    logic [NUM_PORTS*DATA_W-1:0] wr_data;
    logic [NUM_PORTS-1:0]        rd_valid;
    logic                        rd_last;
    logic [DATA_W-1:0]           rd_data;
    logic [NUM_PORTS-1:0]        prot_err;
    logic                        busy;
    logic                        mem_en;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_len, wr_data, mem_rdata,
        output req_ready, wr_ready, wr_beat, rd_valid, rd_last, rd_data,
               prot_err, busy, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_len, wr_data, mem_rdata,
        input  req_ready, wr_ready, wr_beat, rd_valid, rd_last, rd_data,
               prot_err, busy, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_access_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer,
// searching upward with wrap, as both a one-hot grant and an index.
module rr_arbiter
    import chip8_mem_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int IDX_W     = idxWidth(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_ptr,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_any
);

    // Offset k from the pointer maps to port j either directly or after one wrap.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (!o_any && i_req[j] &&
                    ((int'(i_ptr) + k == j) || (int'(i_ptr) + k == j + NUM_PORTS))) begin
                    o_any      = 1'b1;
                    o_grant[j] = 1'b1;
                    o_idx      = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Multi-port burst arbiter in front of the 4 KB single-port CHIP-8 RAM, with
// round-robin grants, 12-bit address wrap and write protection of low memory.
module mem_access_arbiter
    import chip8_mem_pkg::*;
#(
    parameter int                NUM_PORTS = 3,
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                MAX_BURST = 16,
    parameter int                LEN_W     = $clog2(MAX_BURST),
    parameter bit                PROT_EN   = 1'b1,
    parameter logic [ADDR_W-1:0] PROT_END  = ADDR_W'(PROT_END_DEF)
) (
    input logic                 clk,
    input logic                 rst,
    mem_access_arbiter_if.slave bus
);

    localparam int IDX_W = idxWidth(NUM_PORTS);

    state_t               r_state;
    state_t               w_nextState;
    logic [IDX_W-1:0]     r_rrPtr;
    logic [IDX_W-1:0]     r_owner;
    logic                 r_write;
    logic [ADDR_W-1:0]    r_addr;
    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_beat;
    logic                 r_rdPend;
    logic [IDX_W-1:0]     r_rdOwner;
    logic                 r_rdLast;

    logic [NUM_PORTS-1:0] w_grant;
    logic [IDX_W-1:0]     w_grantIdx;
    logic                 w_grantAny;
    logic                 w_accept;
    logic [IDX_W-1:0]     w_nextPtr;
    logic [ADDR_W-1:0]    w_selAddr;
    logic [LEN_W-1:0]     w_selLen;
    logic                 w_selWrite;
    logic [DATA_W-1:0]    w_ownerWdata;
    logic [ADDR_W-1:0]    w_beatAddr;
    logic                 w_lastBeat;
    logic                 w_blocked;
    logic [NUM_PORTS-1:0] w_ownerOh;
    logic [NUM_PORTS-1:0] w_rdOwnerOh;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rrArbiter (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rrPtr),
        .o_grant (w_grant),
        .o_idx   (w_grantIdx),
        .o_any   (w_grantAny)
    );

    // Acceptance is held off while reset is asserted so no request is lost.
    assign w_accept    = (r_state == IDLE) && w_grantAny && !rst;
    assign w_nextPtr   = (w_grantIdx == IDX_W'(NUM_PORTS - 1)) ? '0 : w_grantIdx + 1'b1;
    assign w_beatAddr  = r_addr + ADDR_W'(r_beat);
    assign w_lastBeat  = (r_beat == r_len);
    assign w_blocked   = PROT_EN && (w_beatAddr < PROT_END);
    assign w_ownerOh   = NUM_PORTS'(1) << r_owner;
    assign w_rdOwnerOh = NUM_PORTS'(1) << r_rdOwner;

    always_comb begin
        w_ownerWdata = '0;
        w_selAddr    = '0;
        w_selLen     = '0;
        w_selWrite   = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_owner == IDX_W'(p)) begin
                w_ownerWdata = bus.wr_data[p*DATA_W +: DATA_W];
            end
            if (w_grantIdx == IDX_W'(p)) begin
                w_selAddr  = bus.req_addr[p*ADDR_W +: ADDR_W];
                w_selLen   = bus.req_len[p*LEN_W +: LEN_W];
                w_selWrite = bus.req_write[p];
            end
        end
    end

    always_comb begin
        w_nextState   = r_state;
        bus.req_ready = '0;
        bus.wr_ready  = '0;
        bus.wr_beat   = '0;
        bus.prot_err  = '0;
        bus.busy      = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    bus.req_ready = w_grant;
                    w_nextState   = BURST;
                end
            end
            BURST: begin
                bus.busy     = 1'b1;
                bus.mem_en   = 1'b1;
                bus.mem_addr = w_beatAddr;
                // Blocked write beats still consume a cycle so the client's beat count stays aligned.
                if (r_write) begin
                    bus.wr_ready  = w_ownerOh;
                    bus.wr_beat   = r_beat;
                    bus.mem_wdata = w_ownerWdata;
                    bus.mem_we    = !w_blocked;
                    bus.prot_err  = w_blocked ? w_ownerOh : '0;
                end
                if (w_lastBeat) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rrPtr   <= '0;
            r_owner   <= '0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_rdPend  <= 1'b0;
            r_rdOwner <= '0;
            r_rdLast  <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_rdPend  <= (r_state == BURST) && !r_write;
            r_rdOwner <= r_owner;
            r_rdLast  <= w_lastBeat;
            if (w_accept) begin
                r_owner <= w_grantIdx;
                r_write <= w_selWrite;
                r_addr  <= w_selAddr;
                r_len   <= w_selLen;
                r_beat  <= '0;
                r_rrPtr <= w_nextPtr;
            end else if (r_state == BURST) begin
                r_beat <= w_lastBeat ? '0 : r_beat + 1'b1;
            end
        end
    end

    // Read data returns one cycle after its beat, independent of the FSM state.
    assign bus.rd_valid = r_rdPend ? w_rdOwnerOh : '0;
    assign bus.rd_last  = r_rdPend & r_rdLast;
    assign bus.rd_data  = r_rdPend ? bus.mem_rdata : '0;

endmodule
